// File: rtl/lm32_dp_ram_ctrl_pkg.sv
// Shared encodings for the dual-port RAM controller: sweep FSM states and
// write-port requester ids.
package lm32_dp_ram_ctrl_pkg;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

endpackage

// File: rtl/lm32_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered pointer to the
// last winner. Index RR_A is requester A, RR_B is requester B.
module lm32_rr_arb2
  import lm32_dp_ram_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic rr_last;

  always_comb begin
    gnt = '0;
    if (en) begin
      // On contention the requester that did not win last time goes first.
      if (req[RR_A] && (!req[RR_B] || rr_last == RR_B))
        gnt[RR_A] = 1'b1;
      else if (req[RR_B])
        gnt[RR_B] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      rr_last <= RR_B;
    else if (gnt[RR_A])
      rr_last <= RR_A;
    else if (gnt[RR_B])
      rr_last <= RR_B;
  end

endmodule

// File: rtl/lm32_dp_ram_ctrl.sv
// Front-end for a simple dual-port RAM: init sweep, write-port arbitration and
// read valid tracking. Define LM32_DP_RAM_CTRL_FWD_EN for read-first RAMs.
module lm32_dp_ram_ctrl
  import lm32_dp_ram_ctrl_pkg::*;
#(
  parameter int                    addr_width = 10,
  parameter int                    addr_depth = 1024,
  parameter int                    data_width = 8,
  parameter logic [data_width-1:0] init_value = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  flush_done_o,
  input  logic                  wa_req_i,
  input  logic [addr_width-1:0] wa_addr_i,
  input  logic [data_width-1:0] wa_data_i,
  output logic                  wa_gnt_o,
  input  logic                  wb_req_i,
  input  logic [addr_width-1:0] wb_addr_i,
  input  logic [data_width-1:0] wb_data_i,
  output logic                  wb_gnt_o,
  input  logic                  rd_en_i,
  input  logic [addr_width-1:0] rd_addr_i,
  output logic                  rd_stall_o,
  output logic                  rd_valid_o,
  output logic [data_width-1:0] rd_data_o,
  output logic                  ram_we_o,
  output logic [addr_width-1:0] ram_waddr_o,
  output logic [data_width-1:0] ram_wdata_o,
  output logic [addr_width-1:0] ram_raddr_o,
  input  logic [data_width-1:0] ram_rdata_i
);

  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(addr_depth - 1);

  state_t                state;
  logic [addr_width-1:0] cnt;
  logic                  cnt_last;
  logic [1:0]            gnt;

  assign cnt_last = (cnt == LAST_ADDR);

  lm32_rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req     ({wb_req_i, wa_req_i}),
    .en      (state == ST_RUN),
    .gnt     (gnt)
  );

  assign wa_gnt_o     = gnt[RR_A];
  assign wb_gnt_o     = gnt[RR_B];
  assign busy_o       = (state == ST_FLUSH);
  assign flush_done_o = busy_o & cnt_last & ~flush_i;
  assign rd_stall_o   = busy_o & rd_en_i;
  assign ram_raddr_o  = rd_addr_i;

  always_comb begin
    ram_we_o    = 1'b0;
    ram_waddr_o = wa_addr_i;
    ram_wdata_o = wa_data_i;
    if (busy_o) begin
      ram_we_o    = 1'b1;
      ram_waddr_o = cnt;
      ram_wdata_o = init_value;
    end else if (gnt[RR_B]) begin
      ram_we_o    = 1'b1;
      ram_waddr_o = wb_addr_i;
      ram_wdata_o = wb_data_i;
    end else begin
      ram_we_o    = gnt[RR_A];
    end
  end

  // A flush request, even on the final sweep write, restarts the sweep.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_FLUSH;
      cnt   <= '0;
    end else if (state == ST_FLUSH) begin
      if (flush_i) begin
        cnt <= '0;
      end else if (cnt_last) begin
        state <= ST_RUN;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (flush_i) begin
      state <= ST_FLUSH;
      cnt   <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      rd_valid_o <= 1'b0;
    else
      rd_valid_o <= (state == ST_RUN) & rd_en_i;
  end

`ifdef LM32_DP_RAM_CTRL_FWD_EN
  logic                  fwd_hit_q;
  logic [data_width-1:0] fwd_data_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= ram_we_o & rd_en_i & ~rd_stall_o & (ram_waddr_o == rd_addr_i);
      fwd_data_q <= ram_wdata_o;
    end
  end

  assign rd_data_o = fwd_hit_q ? fwd_data_q : ram_rdata_i;
`else
  assign rd_data_o = ram_rdata_i;
`endif

endmodule

// File: tb/tb_lm32_dp_ram_ctrl.sv
// Directed bench for lm32_dp_ram_ctrl with a read-first RAM model attached.
module tb_lm32_dp_ram_ctrl;

  localparam int         AW   = 5;
  localparam int         DEP  = 16;
  localparam int         DW   = 8;
  localparam logic [7:0] INIT = 8'h3C;

  logic          clk_i = 1'b0, rst_n_i = 1'b0, flush_i = 1'b0;
  logic          busy_o, flush_done_o;
  logic          wa_req_i = 1'b0, wb_req_i = 1'b0, rd_en_i = 1'b0;
  logic [AW-1:0] wa_addr_i = '0, wb_addr_i = '0, rd_addr_i = '0;
  logic [DW-1:0] wa_data_i = '0, wb_data_i = '0;
  logic          wa_gnt_o, wb_gnt_o, rd_stall_o, rd_valid_o, ram_we_o;
  logic [DW-1:0] rd_data_o, ram_wdata_o, ram_rdata_i;
  logic [AW-1:0] ram_waddr_o, ram_raddr_o;

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] exp_mem [32];

  always #5 clk_i = ~clk_i;

  lm32_dp_ram_ctrl #(.addr_width(AW), .addr_depth(DEP), .data_width(DW), .init_value(INIT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .busy_o(busy_o),
    .flush_done_o(flush_done_o), .wa_req_i(wa_req_i), .wa_addr_i(wa_addr_i),
    .wa_data_i(wa_data_i), .wa_gnt_o(wa_gnt_o), .wb_req_i(wb_req_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_gnt_o(wb_gnt_o),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_stall_o(rd_stall_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .ram_we_o(ram_we_o),
    .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o),
    .ram_raddr_o(ram_raddr_o), .ram_rdata_i(ram_rdata_i)
  );

  // Read-first RAM: a same-cycle write is not visible to the read.
  always @(posedge clk_i) begin
    if (ram_we_o) mem[ram_waddr_o] <= ram_wdata_o;
    ram_rdata_i <= mem[ram_raddr_o];
  end

  typedef struct {
    logic          wa_req; logic [AW-1:0] wa_addr; logic [DW-1:0] wa_data;
    logic          wb_req; logic [AW-1:0] wb_addr; logic [DW-1:0] wb_data;
    logic          e_ga, e_gb, e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic ar, input int aa, input int ad,
                              input logic br, input int ba, input int bd,
                              input logic ga, input logic gb, input logic we,
                              input int ea, input int ed);
    vec_t v;
    v.wa_req = ar; v.wa_addr = AW'(aa); v.wa_data = DW'(ad);
    v.wb_req = br; v.wb_addr = AW'(ba); v.wb_data = DW'(bd);
    v.e_ga = ga; v.e_gb = gb; v.e_we = we; v.e_addr = AW'(ea); v.e_data = DW'(ed);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic settle(); #4; endtask
  task automatic tick(); @(posedge clk_i); #1; endtask

  // n sweep cycles starting from address 0; done pulse expected on the last one if done_last.
  task automatic sweep_cycles(input int n, input bit done_last);
    for (int i = 0; i < n; i++) begin
      settle();
      chk("sweep_busy", busy_o, 1);
      chk("sweep_we", ram_we_o, 1);
      chk("sweep_waddr", ram_waddr_o, i);
      chk("sweep_wdata", ram_wdata_o, INIT);
      chk("sweep_gnt", {wa_gnt_o, wb_gnt_o}, 0);
      chk("sweep_stall", rd_stall_o, rd_en_i);
      chk("sweep_rd_valid", rd_valid_o, 0);
      chk("sweep_done", flush_done_o, (done_last && i == n - 1) ? 1 : 0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(1, 1, 'h11, 1, 2, 'h22, 1, 0, 1, 1, 'h11);
    vecs[1]  = mk(1, 1, 'h11, 1, 2, 'h22, 0, 1, 1, 2, 'h22);
    vecs[2]  = mk(1, 1, 'h11, 1, 2, 'h22, 1, 0, 1, 1, 'h11);
    vecs[3]  = mk(1, 1, 'h11, 1, 2, 'h22, 0, 1, 1, 2, 'h22);
    vecs[4]  = mk(0, 7, 'h77, 0, 2, 'h22, 0, 0, 0, 7, 'h77);
    vecs[5]  = mk(0, 7, 'h77, 1, 5, 'h55, 0, 1, 1, 5, 'h55);
    vecs[6]  = mk(0, 7, 'h77, 1, 6, 'h66, 0, 1, 1, 6, 'h66);
    vecs[7]  = mk(0, 7, 'h77, 1, 8, 'h88, 0, 1, 1, 8, 'h88);
    vecs[8]  = mk(1, 9, 'h99, 1, 10, 'hAA, 1, 0, 1, 9, 'h99);
    vecs[9]  = mk(1, 12, 'hCC, 1, 10, 'hAA, 0, 1, 1, 10, 'hAA);
    vecs[10] = mk(1, 12, 'hCC, 0, 0, 0, 1, 0, 1, 12, 'hCC);
    vecs[11] = mk(1, 13, 'hDD, 0, 0, 0, 1, 0, 1, 13, 'hDD);
    vecs[12] = mk(1, 14, 'hEE, 1, 15, 'hFF, 0, 1, 1, 15, 'hFF);
    vecs[13] = mk(1, 14, 'hEE, 0, 0, 0, 1, 0, 1, 14, 'hEE);
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;

    // Reset state, with requests and a read pending that must all be refused.
    wa_req_i = 1; wb_req_i = 1; rd_en_i = 1; rd_addr_i = 5'd2;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", busy_o, 1);
    chk("rst_waddr", ram_waddr_o, 0);
    chk("rst_done", flush_done_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_gnt", {wa_gnt_o, wb_gnt_o}, 0);
    rst_n_i = 1;

    sweep_cycles(DEP, 1);
    for (int i = 0; i < DEP; i++) exp_mem[i] = INIT;
    wa_req_i = 0; wb_req_i = 0; rd_en_i = 0;
    settle();
    chk("run_busy", busy_o, 0);
    chk("run_rd_valid_after_stall", rd_valid_o, 0);
    chk("run_idle_we", ram_we_o, 0);
    tick();

    // Arbitration table.
    for (int i = 0; i < 14; i++) begin
      wa_req_i = vecs[i].wa_req; wa_addr_i = vecs[i].wa_addr; wa_data_i = vecs[i].wa_data;
      wb_req_i = vecs[i].wb_req; wb_addr_i = vecs[i].wb_addr; wb_data_i = vecs[i].wb_data;
      settle();
      chk($sformatf("vec%0d_gnt_a", i), wa_gnt_o, vecs[i].e_ga);
      chk($sformatf("vec%0d_gnt_b", i), wb_gnt_o, vecs[i].e_gb);
      chk($sformatf("vec%0d_we", i), ram_we_o, vecs[i].e_we);
      chk($sformatf("vec%0d_waddr", i), ram_waddr_o, vecs[i].e_addr);
      chk($sformatf("vec%0d_wdata", i), ram_wdata_o, vecs[i].e_data);
      if (vecs[i].e_we) exp_mem[vecs[i].e_addr] = vecs[i].e_data;
      tick();
    end
    wa_req_i = 0; wb_req_i = 0;

    // Back-to-back reads in RUN.
    rd_en_i = 1; rd_addr_i = 5'd5;
    settle();
    chk("rd_stall_run", rd_stall_o, 0);
    chk("rd_raddr", ram_raddr_o, 5);
    tick();
    rd_addr_i = 5'd3;
    settle();
    chk("rd5_valid", rd_valid_o, 1);
    chk("rd5_data", rd_data_o, exp_mem[5]);
    tick();
    rd_en_i = 0;
    settle();
    chk("rd3_valid", rd_valid_o, 1);
    chk("rd3_data", rd_data_o, exp_mem[3]);
    tick();
    settle();
    chk("rd_idle_valid", rd_valid_o, 0);
    tick();

    // Same-address write and read in one cycle.
    wa_req_i = 1; wa_addr_i = 5'd3; wa_data_i = 8'hA5; rd_en_i = 1; rd_addr_i = 5'd3;
    settle();
    chk("fwd_gnt", wa_gnt_o, 1);
    tick();
    wa_req_i = 0; rd_en_i = 0;
    settle();
    chk("fwd_valid", rd_valid_o, 1);
`ifdef LM32_DP_RAM_CTRL_FWD_EN
    chk("fwd_data", rd_data_o, 8'hA5);
`else
    chk("fwd_data", rd_data_o, exp_mem[3]);
`endif
    exp_mem[3] = 8'hA5;
    tick();
    rd_en_i = 1;
    tick();
    rd_en_i = 0;
    settle();
    chk("fwd_reread", rd_data_o, exp_mem[3]);
    tick();

    // Flush from RUN with a simultaneous grant, then restart at address 9.
    wa_req_i = 1; wa_addr_i = 5'd4; wa_data_i = 8'h44; flush_i = 1;
    settle();
    chk("flush_run_gnt", wa_gnt_o, 1);
    chk("flush_run_we", ram_we_o, 1);
    chk("flush_run_busy", busy_o, 0);
    tick();
    wa_req_i = 0; flush_i = 0;
    sweep_cycles(9, 0);
    flush_i = 1;
    settle();
    chk("restart9_waddr", ram_waddr_o, 9);
    chk("restart9_done", flush_done_o, 0);
    tick();
    flush_i = 0;
    sweep_cycles(DEP, 1);
    settle();
    chk("restart9_busy_end", busy_o, 0);
    tick();

    // Flush request on the final sweep write keeps sweeping.
    flush_i = 1;
    tick();
    flush_i = 0;
    sweep_cycles(DEP - 1, 0);
    flush_i = 1;
    settle();
    chk("last_flush_waddr", ram_waddr_o, DEP - 1);
    chk("last_flush_done", flush_done_o, 0);
    tick();
    flush_i = 0;
    sweep_cycles(DEP, 1);
    settle();
    chk("last_flush_busy_end", busy_o, 0);

    // Address 4 was granted a write just before the sweep, which wiped it.
    rd_en_i = 1; rd_addr_i = 5'd4;
    tick();
    rd_en_i = 0;
    settle();
    chk("wiped_valid", rd_valid_o, 1);
    chk("wiped_data", rd_data_o, INIT);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
